// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler: arbitrates pipeline writeback against buffered
// long-op responses and keeps a pending-write scoreboard that drives the decode hazard stall.
module regfile_wb_sched #(
  parameter int RESP_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_data,
  input  logic [4:0]  dec_rs1,
  input  logic [4:0]  dec_rs2,
  input  logic        dec_rs1_used,
  input  logic        dec_rs2_used,
  input  logic [4:0]  dec_rd,
  input  logic        dec_we,
  input  logic        lop_issue_valid,
  input  logic [4:0]  lop_issue_rd,
  input  logic        lop_resp_valid,
  input  logic [4:0]  lop_resp_rd,
  input  logic [31:0] lop_resp_data,
  output logic        lop_resp_ready,
  output logic        hazard_stall,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wb_data,
  output logic        sb_err
);

  localparam int AW = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RESP_DEPTH);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  logic [31:0]   pend_q, pend_d;
  logic [4:0]    rd_mem_q   [RESP_DEPTH];
  logic [4:0]    rd_mem_d   [RESP_DEPTH];
  logic [31:0]   data_mem_q [RESP_DEPTH];
  logic [31:0]   data_mem_d [RESP_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WW-1:0] wait_q, wait_d;
  logic          sb_err_q, sb_err_d;

  logic          pipe_fire;
  logic          buf_empty;
  logic          buf_full;
  logic          push;
  logic          pop;
  logic          force_bubble;
  logic          hazard_raw;
  logic          issue_fire;
  logic [4:0]    head_rd;
  logic [31:0]   head_data;
  logic          arb_we;
  logic [4:0]    arb_rd;
  logic [31:0]   arb_data;

  always_comb begin
    pipe_fire    = pipe_we & (pipe_rd != 5'd0) & ~stall_in;
    buf_empty    = (cnt_q == '0);
    buf_full     = (cnt_q == FULL_CNT);
    head_rd      = rd_mem_q[rd_ptr_q];
    head_data    = data_mem_q[rd_ptr_q];
    push         = lop_resp_valid & ~buf_full;
    pop          = ~buf_empty & ~pipe_fire;
    force_bubble = (wait_q >= WAIT_MAX);
    hazard_raw   = (dec_rs1_used & pend_q[dec_rs1])
                 | (dec_rs2_used & pend_q[dec_rs2])
                 | (dec_we & pend_q[dec_rd])
                 | (lop_issue_valid & pend_q[lop_issue_rd])
                 | force_bubble;
    issue_fire   = lop_issue_valid & ~hazard_stall & (lop_issue_rd != 5'd0);
  end

  // Pipeline always owns the port; the buffer head only drains on idle cycles.
  always_comb begin
    arb_we   = 1'b0;
    arb_rd   = 5'd0;
    arb_data = 32'd0;
    if (pipe_fire) begin
      arb_we   = 1'b1;
      arb_rd   = pipe_rd;
      arb_data = pipe_data;
    end else if (!buf_empty) begin
      arb_we   = (head_rd != 5'd0);
      arb_rd   = head_rd;
      arb_data = head_data;
    end
  end

  assign rf_we          = arb_we & ~reset;
  assign rf_rd          = arb_rd;
  assign rf_wb_data     = arb_data;
  assign hazard_stall   = hazard_raw & ~reset;
  assign lop_resp_ready = ~buf_full;
  assign sb_err         = sb_err_q;

  always_comb begin
    rd_mem_d   = rd_mem_q;
    data_mem_d = data_mem_q;
    if (push) begin
      rd_mem_d[wr_ptr_q]   = lop_resp_rd;
      data_mem_d[wr_ptr_q] = lop_resp_data;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Starvation age of the head: only grows while the pipeline keeps winning.
    wait_d = wait_q;
    if (pop || buf_empty) begin
      wait_d = '0;
    end else if (pipe_fire && (wait_q < WAIT_MAX)) begin
      wait_d = wait_q + WW'(1);
    end

    sb_err_d = sb_err_q | (push & (lop_resp_rd != 5'd0) & ~pend_q[lop_resp_rd]);

    pend_d = pend_q;
    if (pop) begin
      pend_d[head_rd] = 1'b0;
    end
    if (issue_fire) begin
      pend_d[lop_issue_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      sb_err_q <= sb_err_d;
    end
  end

  always_ff @(posedge clk) begin
    rd_mem_q   <= rd_mem_d;
    data_mem_q <= data_mem_d;
  end

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Directed bench for regfile_wb_sched: register-file writes are checked by a queue-based
// monitor; stall, ready and error flags are checked inline by the stimulus.
module tb_regfile_wb_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_in;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic [4:0]  dec_rs1;
  logic [4:0]  dec_rs2;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic [4:0]  dec_rd;
  logic        dec_we;
  logic        lop_issue_valid;
  logic [4:0]  lop_issue_rd;
  logic        lop_resp_valid;
  logic [4:0]  lop_resp_rd;
  logic [31:0] lop_resp_data;
  logic        lop_resp_ready;
  logic        hazard_stall;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wb_data;
  logic        sb_err;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  regfile_wb_sched dut (
    .clk            (clk),
    .reset          (reset),
    .stall_in       (stall_in),
    .pipe_we        (pipe_we),
    .pipe_rd        (pipe_rd),
    .pipe_data      (pipe_data),
    .dec_rs1        (dec_rs1),
    .dec_rs2        (dec_rs2),
    .dec_rs1_used   (dec_rs1_used),
    .dec_rs2_used   (dec_rs2_used),
    .dec_rd         (dec_rd),
    .dec_we         (dec_we),
    .lop_issue_valid(lop_issue_valid),
    .lop_issue_rd   (lop_issue_rd),
    .lop_resp_valid (lop_resp_valid),
    .lop_resp_rd    (lop_resp_rd),
    .lop_resp_data  (lop_resp_data),
    .lop_resp_ready (lop_resp_ready),
    .hazard_stall   (hazard_stall),
    .rf_we          (rf_we),
    .rf_rd          (rf_rd),
    .rf_wb_data     (rf_wb_data),
    .sb_err         (sb_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rf_we) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rf_rd, rf_wb_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (rf_rd !== e.rd || rf_wb_data !== e.data) begin
          n_fail++;
          $display("FAIL rf_write: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_rd, rf_wb_data, e.rd, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wr_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall_in        = 1'b0;
    pipe_we         = 1'b0;
    pipe_rd         = 5'd0;
    pipe_data       = 32'd0;
    dec_rs1         = 5'd0;
    dec_rs2         = 5'd0;
    dec_rs1_used    = 1'b0;
    dec_rs2_used    = 1'b0;
    dec_rd          = 5'd0;
    dec_we          = 1'b0;
    lop_issue_valid = 1'b0;
    lop_issue_rd    = 5'd0;
    lop_resp_valid  = 1'b0;
    lop_resp_rd     = 5'd0;
    lop_resp_data   = 32'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] rd, input logic [31:0] data);
    pipe_we   = 1'b1;
    pipe_rd   = rd;
    pipe_data = data;
    expect_wr(rd, data);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    step();
    // Write request while reset is held must not reach the register file.
    pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1111_1111;
    mid();
    chk("reset_rf_we", rf_we, 1'b0);
    chk("reset_hazard", hazard_stall, 1'b0);
    step();
    reset = 1'b0;
    idle_inputs();
    mid();
    chk("idle_rf_we", rf_we, 1'b0);
    chk("idle_hazard", hazard_stall, 1'b0);
    chk("idle_ready", lop_resp_ready, 1'b1);
    chk("idle_sb_err", sb_err, 1'b0);

    // Pipeline writeback, stalled and x0 variants
    step();
    drive_pipe(5'd5, 32'h5555_5555);
    mid();
    step();
    stall_in = 1'b1;
    mid();
    chk("stall_rf_we", rf_we, 1'b0);
    step();
    stall_in = 1'b0; pipe_rd = 5'd0;
    mid();
    chk("x0_rf_we", rf_we, 1'b0);
    step();
    idle_inputs();

    // Long-op RAW: issue x7, decode reads x7, response drains after one buffered cycle
    lop_issue_valid = 1'b1; lop_issue_rd = 5'd7;
    mid();
    chk("raw_issue_hazard", hazard_stall, 1'b0);
    step();
    lop_issue_valid = 1'b0;
    dec_rs1 = 5'd7; dec_rs1_used = 1'b1;
    mid();
    chk("raw_hazard", hazard_stall, 1'b1);
    step();
    lop_resp_valid = 1'b1; lop_resp_rd = 5'd7; lop_resp_data = 32'hDEAD_BEEF;
    mid();
    chk("raw_resp_ready", lop_resp_ready, 1'b1);
    chk("raw_no_bypass", rf_we, 1'b0);
    chk("raw_hazard_resp", hazard_stall, 1'b1);
    step();
    lop_resp_valid = 1'b0;
    expect_wr(5'd7, 32'hDEAD_BEEF);
    mid();
    chk("raw_hazard_drain", hazard_stall, 1'b1);
    step();
    mid();
    chk("raw_hazard_release", hazard_stall, 1'b0);
    step();
    idle_inputs();

    // Starvation: x3 response held off by continuous pipeline writes
    lop_issue_valid = 1'b1; lop_issue_rd = 5'd3;
    mid();
    step();
    lop_issue_valid = 1'b0;
    drive_pipe(5'd10, 32'h0000_00A0);
    lop_resp_valid = 1'b1; lop_resp_rd = 5'd3; lop_resp_data = 32'h3333_3333;
    mid();
    chk("starve_hazard_push", hazard_stall, 1'b0);
    step();
    lop_resp_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive_pipe(5'(11 + i), 32'hB000_0000 + i);
      mid();
      chk($sformatf("starve_hazard_%0d", i), hazard_stall, (i >= 4) ? 1'b1 : 1'b0);
      step();
    end
    pipe_we = 1'b0;
    expect_wr(5'd3, 32'h3333_3333);
    mid();
    chk("starve_hazard_drain", hazard_stall, 1'b1);
    step();
    mid();
    chk("starve_hazard_release", hazard_stall, 1'b0);
    step();
    idle_inputs();

    // Backpressure with a two-entry buffer; drain order must match push order
    for (int i = 12; i < 15; i++) begin
      lop_issue_valid = 1'b1; lop_issue_rd = 5'(i);
      mid();
      chk($sformatf("bp_issue_hazard_%0d", i), hazard_stall, 1'b0);
      step();
    end
    lop_issue_valid = 1'b0;
    drive_pipe(5'd20, 32'hC000_0001);
    lop_resp_valid = 1'b1; lop_resp_rd = 5'd12; lop_resp_data = 32'hC12C_12C1;
    mid();
    chk("bp_ready_c1", lop_resp_ready, 1'b1);
    step();
    drive_pipe(5'd21, 32'hC000_0002);
    lop_resp_rd = 5'd13; lop_resp_data = 32'hC13C_13C1;
    mid();
    chk("bp_ready_c2", lop_resp_ready, 1'b1);
    step();
    drive_pipe(5'd22, 32'hC000_0003);
    lop_resp_rd = 5'd14; lop_resp_data = 32'hC14C_14C1;
    mid();
    chk("bp_ready_c3", lop_resp_ready, 1'b0);
    step();
    drive_pipe(5'd23, 32'hC000_0004);
    mid();
    chk("bp_ready_c4", lop_resp_ready, 1'b0);
    step();
    pipe_we = 1'b0;
    expect_wr(5'd12, 32'hC12C_12C1);
    mid();
    chk("bp_ready_c5", lop_resp_ready, 1'b0);
    step();
    expect_wr(5'd13, 32'hC13C_13C1);
    mid();
    chk("bp_ready_c6", lop_resp_ready, 1'b1);
    step();
    lop_resp_valid = 1'b0;
    expect_wr(5'd14, 32'hC14C_14C1);
    mid();
    step();
    mid();
    chk("bp_empty_rf_we", rf_we, 1'b0);
    step();
    idle_inputs();

    // Response for a non-pending register raises the sticky error
    lop_resp_valid = 1'b1; lop_resp_rd = 5'd9; lop_resp_data = 32'h9999_9999;
    mid();
    chk("err_before", sb_err, 1'b0);
    step();
    lop_resp_valid = 1'b0;
    expect_wr(5'd9, 32'h9999_9999);
    mid();
    chk("err_set", sb_err, 1'b1);
    step();
    mid();
    chk("err_sticky", sb_err, 1'b1);
    step();

    // WAW and re-issue to a pending register
    lop_issue_valid = 1'b1; lop_issue_rd = 5'd4;
    mid();
    chk("waw_first_issue", hazard_stall, 1'b0);
    step();
    mid();
    chk("waw_reissue_hazard", hazard_stall, 1'b1);
    step();
    lop_issue_valid = 1'b0;
    dec_we = 1'b1; dec_rd = 5'd4;
    mid();
    chk("waw_dec_hazard", hazard_stall, 1'b1);
    step();
    lop_resp_valid = 1'b1; lop_resp_rd = 5'd4; lop_resp_data = 32'h4444_4444;
    mid();
    step();
    lop_resp_valid = 1'b0;
    expect_wr(5'd4, 32'h4444_4444);
    mid();
    chk("waw_hazard_drain", hazard_stall, 1'b1);
    step();
    mid();
    chk("waw_hazard_release", hazard_stall, 1'b0);
    chk("waw_err_still", sb_err, 1'b1);
    step();
    idle_inputs();

    // Reset with a pending register and a buffered response
    lop_issue_valid = 1'b1; lop_issue_rd = 5'd20;
    mid();
    step();
    lop_issue_valid = 1'b0;
    drive_pipe(5'd21, 32'h2121_2121);
    lop_resp_valid = 1'b1; lop_resp_rd = 5'd20; lop_resp_data = 32'h2020_2020;
    dec_rs2 = 5'd20; dec_rs2_used = 1'b1;
    mid();
    chk("rst_pend_hazard", hazard_stall, 1'b1);
    step();
    reset = 1'b1;
    pipe_we = 1'b0; lop_resp_valid = 1'b0;
    mid();
    chk("rst_mid_rf_we", rf_we, 1'b0);
    chk("rst_mid_hazard", hazard_stall, 1'b0);
    step();
    reset = 1'b0;
    mid();
    chk("rst_after_rf_we", rf_we, 1'b0);
    chk("rst_after_hazard", hazard_stall, 1'b0);
    chk("rst_after_ready", lop_resp_ready, 1'b1);
    chk("rst_after_sb_err", sb_err, 1'b0);
    step();
    idle_inputs();
    repeat (3) step();
    mid();
    chk("exp_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
